// File: rtl/db_pkg.sv
// Shared defaults and FSM state encoding for the read address generator.
package db_pkg;

  localparam int DB_NUM_DIMS = 6;
  localparam int DB_AW       = 16;
  localparam int DB_RW       = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;

endpackage

// File: rtl/db_read_addr_gen_if.sv
// Read-address channel plus bank-swap handshake between the generator and
// the memory core.
//
// Handshake rules:
//   rd_valid/rd_ready: an address transfers on a clock edge where both are
//   high (and the global clock enable is high). Once rd_valid rises, rd_addr
//   and rd_valid hold until that transfer happens; rd_ready may toggle freely.
//   switch_req/switch_ack: switch_req stays high until the edge where
//   switch_ack is seen high; switch_ack outside a request has no effect.
interface db_read_addr_gen_if
  import db_pkg::*;
#(
  parameter int AW = DB_AW
);

  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] rd_addr;
  logic          rd_bank;
  logic          switch_req;
  logic          switch_ack;

  modport master (
    output rd_valid, rd_addr, rd_bank, switch_req,
    input  rd_ready, switch_ack
  );

  modport slave (
    input  rd_valid, rd_addr, rd_bank, switch_req,
    output rd_ready, switch_ack
  );

endinterface

// File: rtl/db_dim_counter.sv
// One loop dimension's index counter: counts 0..range-1 on carry-in, wraps
// to 0 and raises carry-out on the wrapping step. A range of 0 acts as 1.
module db_dim_counter #(
  parameter int RW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_active,
  input  logic          i_carry_in,
  input  logic [RW-1:0] i_range,
  output logic [RW-1:0] o_idx_next,
  output logic          o_carry_out
);

  logic [RW-1:0] r_idx;
  logic [RW-1:0] w_range_eff;
  logic          w_at_max;
  logic          w_inc;

  assign w_range_eff = (i_range == '0) ? RW'(1) : i_range;
  assign w_at_max    = (r_idx == (w_range_eff - RW'(1)));
  assign w_inc       = i_carry_in & i_active;
  assign o_carry_out = w_inc & w_at_max;

  // Next index: clear wins, otherwise step with wrap on carry-in.
  always_comb begin
    o_idx_next = r_idx;
    if (i_clr) begin
      o_idx_next = '0;
    end else if (w_inc) begin
      o_idx_next = w_at_max ? '0 : (r_idx + RW'(1));
    end
  end

  // Index register.
  always_ff @(posedge clk) begin
    if (reset) r_idx <= '0;
    else       r_idx <= o_idx_next;
  end

endmodule

// File: rtl/db_read_addr_gen.sv
// Double-buffer read address generator: walks a nested loop of up to
// NUM_DIMS dimensions, emitting starting_addr + sum(idx[i]*stride[i]) per
// transfer, then requests a bank swap and pulses done.
module db_read_addr_gen
  import db_pkg::*;
#(
  parameter int NUM_DIMS = DB_NUM_DIMS,
  parameter int AW       = DB_AW,
  parameter int RW       = DB_RW
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clk_en,
  input  logic                         flush,
  input  logic                         start,
  input  logic [AW-1:0]                starting_addr,
  input  logic [3:0]                   dimensionality,
  input  logic [NUM_DIMS-1:0][AW-1:0]  stride,
  input  logic [NUM_DIMS-1:0][RW-1:0]  range,
  input  logic [RW-1:0]                iter_cnt,
  db_read_addr_gen_if.master           rd_if,
  output logic                         done,
  output logic                         cfg_err,
  output state_t                       dbg_state
);

  state_t                      r_state;
  logic                        r_rd_valid;
  logic [AW-1:0]               r_rd_addr;
  logic                        r_rd_bank;
  logic                        r_switch_req;
  logic                        r_done;
  logic                        r_cfg_err;
  logic [RW-1:0]               r_pass_cnt;

  logic                        w_legal;
  logic                        w_load;
  logic                        w_clr;
  logic                        w_transfer;
  logic                        w_pass_wrap;
  logic                        w_last;
  logic [NUM_DIMS-1:0]         w_active;
  logic [NUM_DIMS-1:0]         w_cin;
  logic [NUM_DIMS-1:0]         w_carry;
  logic [NUM_DIMS-1:0][RW-1:0] w_idx_next;
  logic [AW-1:0]               w_next_addr;
  logic [RW+AW-1:0]            w_prod;

  assign w_legal    = (iter_cnt != '0) && (dimensionality != 4'd0) &&
                      (int'(dimensionality) <= NUM_DIMS);
  // A start in the cycle done is high belongs to the finished pass; drop it.
  assign w_load     = (r_state == ST_IDLE) & clk_en & start & ~r_done & w_legal;
  assign w_clr      = flush | w_load;
  assign w_transfer = r_rd_valid & rd_if.rd_ready & clk_en;
  assign w_last     = w_pass_wrap | (r_pass_cnt == (iter_cnt - RW'(1)));

  // Dimensions at or above dimensionality never count and never carry.
  always_comb begin
    w_active = '0;
    for (int i = 0; i < NUM_DIMS; i++) begin
      w_active[i] = (i < int'(dimensionality));
    end
  end

  // Carry chain: the transfer steps dim 0, each wrap steps the next dim.
  for (genvar g = 0; g < NUM_DIMS; g++) begin : g_dim
    if (g == 0) begin : g_first
      assign w_cin[g] = w_transfer;
    end else begin : g_rest
      assign w_cin[g] = w_carry[g-1];
    end

    db_dim_counter #(.RW(RW)) u_cnt (
      .clk         (clk),
      .reset       (reset),
      .i_clr       (w_clr),
      .i_active    (w_active[g]),
      .i_carry_in  (w_cin[g]),
      .i_range     (range[g]),
      .o_idx_next  (w_idx_next[g]),
      .o_carry_out (w_carry[g])
    );
  end

  // Pass wrap is the carry out of the outermost active dimension.
  always_comb begin
    w_pass_wrap = 1'b0;
    for (int i = 0; i < NUM_DIMS; i++) begin
      if (int'(dimensionality) == i + 1) w_pass_wrap = w_pass_wrap | w_carry[i];
    end
  end

  // Address for the upcoming index vector, modulo 2^AW.
  always_comb begin
    w_next_addr = starting_addr;
    w_prod      = '0;
    for (int i = 0; i < NUM_DIMS; i++) begin
      w_prod = {{AW{1'b0}}, w_idx_next[i]} * {{RW{1'b0}}, stride[i]};
      if (w_active[i]) w_next_addr = w_next_addr + w_prod[AW-1:0];
    end
  end

  // Control FSM with registered outputs; flush acts like reset regardless of clk_en.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_state      <= ST_IDLE;
      r_rd_valid   <= 1'b0;
      r_rd_addr    <= '0;
      r_rd_bank    <= 1'b0;
      r_switch_req <= 1'b0;
      r_done       <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_pass_cnt   <= '0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      if (clk_en) begin
        case (r_state)
          ST_IDLE: begin
            if (w_load) begin
              r_state    <= ST_RUN;
              r_rd_valid <= 1'b1;
              r_rd_addr  <= w_next_addr;
              r_pass_cnt <= '0;
            end else if (start && !r_done && !w_legal) begin
              r_cfg_err <= 1'b1;
            end
          end
          ST_RUN: begin
            if (w_transfer) begin
              r_rd_addr <= w_next_addr;
              if (w_last) begin
                r_state      <= ST_SWITCH;
                r_rd_valid   <= 1'b0;
                r_switch_req <= 1'b1;
              end else begin
                r_pass_cnt <= r_pass_cnt + RW'(1);
              end
            end
          end
          ST_SWITCH: begin
            if (rd_if.switch_ack) begin
              r_state      <= ST_IDLE;
              r_switch_req <= 1'b0;
              r_rd_bank    <= ~r_rd_bank;
              r_done       <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign rd_if.rd_valid   = r_rd_valid;
  assign rd_if.rd_addr    = r_rd_addr;
  assign rd_if.rd_bank    = r_rd_bank;
  assign rd_if.switch_req = r_switch_req;
  assign done             = r_done;
  assign cfg_err          = r_cfg_err;
  assign dbg_state        = r_state;

endmodule

// File: tb/tb_db_read_addr_gen.sv
// Directed bench for db_read_addr_gen: one task per scenario, inline checks.
module tb_db_read_addr_gen;
  import db_pkg::*;

  localparam int ND = 6;
  localparam int AW = 16;
  localparam int RW = 32;

  logic                   clk;
  logic                   reset;
  logic                   clk_en;
  logic                   flush;
  logic                   start;
  logic [AW-1:0]          starting_addr;
  logic [3:0]             dimensionality;
  logic [ND-1:0][AW-1:0]  stride;
  logic [ND-1:0][RW-1:0]  range;
  logic [RW-1:0]          iter_cnt;
  logic                   done;
  logic                   cfg_err;
  state_t                 dbg_state;

  int checks   = 0;
  int failures = 0;

  db_read_addr_gen_if #(.AW(AW)) rd_if ();

  db_read_addr_gen #(.NUM_DIMS(ND), .AW(AW), .RW(RW)) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_en         (clk_en),
    .flush          (flush),
    .start          (start),
    .starting_addr  (starting_addr),
    .dimensionality (dimensionality),
    .stride         (stride),
    .range          (range),
    .iter_cnt       (iter_cnt),
    .rd_if          (rd_if.slave),
    .done           (done),
    .cfg_err        (cfg_err),
    .dbg_state      (dbg_state)
  );

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs set afterwards apply at the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; clk_en = 1'b1; flush = 1'b0; start = 1'b0;
    rd_if.rd_ready = 1'b1; rd_if.switch_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // 3-D cube config: strides 1/3/9, ranges 3/3/3; dims 3..5 hold junk.
  task automatic set_cfg3(input logic [RW-1:0] iters);
    starting_addr  = '0;
    dimensionality = 4'd3;
    stride = '0; range = '0;
    stride[0] = 16'd1; stride[1] = 16'd3; stride[2] = 16'd9;
    range[0]  = 32'd3; range[1]  = 32'd3; range[2]  = 32'd3;
    stride[3] = 16'h1234; range[3] = 32'd7;
    stride[5] = 16'h0F0F; range[5] = 32'd2;
    iter_cnt = iters;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rd_if.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid: got %0b want 0", rd_if.rd_valid); end
    checks++; if (rd_if.rd_addr !== 16'h0) begin failures++; $display("FAIL reset_rd_addr: got %0h want 0", rd_if.rd_addr); end
    checks++; if (rd_if.rd_bank !== 1'b0) begin failures++; $display("FAIL reset_rd_bank: got %0b want 0", rd_if.rd_bank); end
    checks++; if (rd_if.switch_req !== 1'b0) begin failures++; $display("FAIL reset_switch_req: got %0b want 0", rd_if.switch_req); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b want 0", done); end
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err: got %0b want 0", cfg_err); end
    checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_full_pass();
    do_reset();
    set_cfg3(32'd27);
    pulse_start();
    for (int k = 0; k < 27; k++) begin
      checks++;
      if (rd_if.rd_valid !== 1'b1 || rd_if.rd_addr !== 16'(k)) begin
        failures++; $display("FAIL full_addr[%0d]: got v=%0b a=%0d want v=1 a=%0d", k, rd_if.rd_valid, rd_if.rd_addr, k);
      end
      tick();
    end
    checks++; if (rd_if.rd_valid !== 1'b0 || rd_if.switch_req !== 1'b1) begin failures++; $display("FAIL full_end: got v=%0b sreq=%0b want v=0 sreq=1", rd_if.rd_valid, rd_if.switch_req); end
    rd_if.switch_ack = 1'b1; tick(); rd_if.switch_ack = 1'b0;
    checks++; if (done !== 1'b1 || rd_if.rd_bank !== 1'b1 || rd_if.switch_req !== 1'b0) begin failures++; $display("FAIL full_swap: got done=%0b bank=%0b sreq=%0b want 1 1 0", done, rd_if.rd_bank, rd_if.switch_req); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL full_done_pulse: got %0b want 0", done); end
  endtask

  task automatic test_backpressure();
    int e;
    int cyc;
    do_reset();
    set_cfg3(32'd27);
    pulse_start();
    e = 0; cyc = 0;
    while (e < 27 && cyc < 200) begin
      checks++;
      if (rd_if.rd_valid !== 1'b1 || rd_if.rd_addr !== 16'(e)) begin
        failures++; $display("FAIL bp_addr[%0d]: got v=%0b a=%0d want v=1 a=%0d", cyc, rd_if.rd_valid, rd_if.rd_addr, e);
      end
      rd_if.rd_ready = (cyc % 2 == 0);
      tick();
      if (rd_if.rd_ready) e++;
      cyc++;
    end
    rd_if.rd_ready = 1'b1;
    checks++; if (e != 27) begin failures++; $display("FAIL bp_timeout: got %0d transfers want 27", e); end
    checks++; if (rd_if.rd_valid !== 1'b0 || rd_if.switch_req !== 1'b1) begin failures++; $display("FAIL bp_end: got v=%0b sreq=%0b want v=0 sreq=1", rd_if.rd_valid, rd_if.switch_req); end
  endtask

  task automatic test_iter_limit();
    do_reset();
    set_cfg3(32'd10);
    pulse_start();
    rd_if.switch_ack = 1'b1;  // must be ignored while running
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (rd_if.rd_valid !== 1'b1 || rd_if.rd_addr !== 16'(k)) begin
        failures++; $display("FAIL iter_addr[%0d]: got v=%0b a=%0d want v=1 a=%0d", k, rd_if.rd_valid, rd_if.rd_addr, k);
      end
      if (k == 9) rd_if.switch_ack = 1'b0;
      tick();
    end
    checks++; if (rd_if.rd_valid !== 1'b0 || rd_if.switch_req !== 1'b1 || rd_if.rd_bank !== 1'b0) begin failures++; $display("FAIL iter_switch: got v=%0b sreq=%0b bank=%0b want 0 1 0", rd_if.rd_valid, rd_if.switch_req, rd_if.rd_bank); end
    start = 1'b1;  // ignored in SWITCH and in the done cycle
    tick(); tick();
    checks++; if (rd_if.switch_req !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL iter_hold_req: got sreq=%0b done=%0b want 1 0", rd_if.switch_req, done); end
    rd_if.switch_ack = 1'b1; tick(); rd_if.switch_ack = 1'b0;
    checks++; if (done !== 1'b1 || rd_if.rd_bank !== 1'b1) begin failures++; $display("FAIL iter_swap: got done=%0b bank=%0b want 1 1", done, rd_if.rd_bank); end
    tick(); start = 1'b0;
    checks++; if (done !== 1'b0 || rd_if.rd_valid !== 1'b0) begin failures++; $display("FAIL iter_start_in_done: got done=%0b v=%0b want 0 0", done, rd_if.rd_valid); end
  endtask

  // Runs straight after test_iter_limit so the bank is 1 going in.
  task automatic test_flush();
    set_cfg3(32'd27);
    pulse_start();
    repeat (5) tick();
    checks++; if (rd_if.rd_addr !== 16'd5) begin failures++; $display("FAIL flush_pre_addr: got %0d want 5", rd_if.rd_addr); end
    flush = 1'b1; tick(); flush = 1'b0;
    checks++; if (rd_if.rd_valid !== 1'b0 || rd_if.rd_bank !== 1'b0 || rd_if.rd_addr !== 16'd0) begin failures++; $display("FAIL flush_clear: got v=%0b bank=%0b a=%0d want 0 0 0", rd_if.rd_valid, rd_if.rd_bank, rd_if.rd_addr); end
    pulse_start();
    checks++; if (rd_if.rd_valid !== 1'b1 || rd_if.rd_addr !== 16'd0) begin failures++; $display("FAIL flush_restart0: got v=%0b a=%0d want 1 0", rd_if.rd_valid, rd_if.rd_addr); end
    tick();
    checks++; if (rd_if.rd_addr !== 16'd1) begin failures++; $display("FAIL flush_restart1: got %0d want 1", rd_if.rd_addr); end
  endtask

  task automatic test_cfg_err();
    logic [3:0] bad_dims [3];
    logic [RW-1:0] bad_iter [3];
    bad_dims[0] = 4'd3; bad_iter[0] = 32'd0;
    bad_dims[1] = 4'd0; bad_iter[1] = 32'd27;
    bad_dims[2] = 4'd7; bad_iter[2] = 32'd27;
    do_reset();
    for (int n = 0; n < 3; n++) begin
      set_cfg3(bad_iter[n]);
      dimensionality = bad_dims[n];
      pulse_start();
      checks++; if (cfg_err !== 1'b1 || rd_if.rd_valid !== 1'b0) begin failures++; $display("FAIL cfg_err_pulse[%0d]: got err=%0b v=%0b want 1 0", n, cfg_err, rd_if.rd_valid); end
      tick();
      checks++; if (cfg_err !== 1'b0 || rd_if.rd_valid !== 1'b0) begin failures++; $display("FAIL cfg_err_clear[%0d]: got err=%0b v=%0b want 0 0", n, cfg_err, rd_if.rd_valid); end
    end
  endtask

  task automatic test_clk_en();
    do_reset();
    set_cfg3(32'd27);
    pulse_start();
    repeat (3) tick();
    clk_en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (rd_if.rd_valid !== 1'b1 || rd_if.rd_addr !== 16'd3) begin failures++; $display("FAIL clken_frozen[%0d]: got v=%0b a=%0d want 1 3", c, rd_if.rd_valid, rd_if.rd_addr); end
    end
    clk_en = 1'b1;
    for (int k = 3; k < 27; k++) begin
      checks++; if (rd_if.rd_addr !== 16'(k)) begin failures++; $display("FAIL clken_addr[%0d]: got %0d want %0d", k, rd_if.rd_addr, k); end
      tick();
    end
    checks++; if (rd_if.switch_req !== 1'b1) begin failures++; $display("FAIL clken_end: got sreq=%0b want 1", rd_if.switch_req); end
  endtask

  // range 0 acts as 1, unused dims ignored, address wraps modulo 2^16.
  task automatic test_range_zero();
    logic [AW-1:0] exp_v [3];
    exp_v[0] = 16'hFFFE; exp_v[1] = 16'h0002; exp_v[2] = 16'h0006;
    do_reset();
    set_cfg3(32'd27);
    starting_addr = 16'hFFFE;
    dimensionality = 4'd2;
    stride[0] = 16'd1; range[0] = 32'd0;
    stride[1] = 16'd4; range[1] = 32'd3;
    stride[2] = 16'd100; range[2] = 32'd5;
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      checks++; if (rd_if.rd_valid !== 1'b1 || rd_if.rd_addr !== exp_v[k]) begin failures++; $display("FAIL rz_addr[%0d]: got v=%0b a=%0h want 1 %0h", k, rd_if.rd_valid, rd_if.rd_addr, exp_v[k]); end
      tick();
    end
    checks++; if (rd_if.rd_valid !== 1'b0 || rd_if.switch_req !== 1'b1) begin failures++; $display("FAIL rz_wrap: got v=%0b sreq=%0b want 0 1", rd_if.rd_valid, rd_if.switch_req); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_cfg3(32'd27);
    pulse_start();
    repeat (4) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (rd_if.rd_valid !== 1'b0 || rd_if.rd_addr !== 16'd0 || done !== 1'b0 || rd_if.switch_req !== 1'b0) begin failures++; $display("FAIL reset_mid: got v=%0b a=%0d done=%0b sreq=%0b want 0 0 0 0", rd_if.rd_valid, rd_if.rd_addr, done, rd_if.switch_req); end
    tick();
    checks++; if (done !== 1'b0 || dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_mid_idle: got done=%0b st=%0d want 0 %0d", done, dbg_state, ST_IDLE); end
  endtask

  initial begin
    set_cfg3(32'd27);
    test_reset();
    test_full_pass();
    test_backpressure();
    test_iter_limit();
    test_flush();
    test_cfg_err();
    test_clk_en();
    test_range_zero();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
